// File: rtl/display_pkg.sv
// Shared definitions for the 96-word display window and its scan-out FSM.
package display_pkg;
  localparam int DIS_WORDS = 96;
  localparam int FB_ROWS   = 48;
  localparam int FB_WPR    = 2;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, ROW_GAP, FRAME_GAP} scan_state_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction
endpackage

// File: rtl/scan_row_shifter.sv
// Row snapshot register: loads one framebuffer row, shifts it out MSB first.
module scan_row_shifter
  import display_pkg::*;
#(
  parameter int PIX = 64,
  parameter int BW  = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           shift,
  input  logic [PIX-1:0] row_bits,
  output logic           data,
  output logic           eol,
  output logic [BW-1:0]  bit_cnt
);

  logic [PIX-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      sr      <= row_bits;
      bit_cnt <= '0;
    end else if (shift) begin
      sr      <= {sr[PIX-2:0], 1'b0};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign data = sr[PIX-1];
  assign eol  = (bit_cnt == BW'(PIX - 1));

endmodule

// File: rtl/display_scanout.sv
// Serialises the display window as a 1-bpp pixel stream with row/frame markers.
module display_scanout
  import display_pkg::scan_state_t, display_pkg::clog2_min1;
#(
  parameter int ROWS          = display_pkg::FB_ROWS,
  parameter int WORDS_PER_ROW = display_pkg::FB_WPR,
  parameter int ROW_GAP       = 4,
  parameter int FRAME_GAP     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] dis [0:display_pkg::DIS_WORDS-1],
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output scan_state_t dbg_state
);

  localparam int PIX  = 32 * WORDS_PER_ROW;
  localparam int BW   = clog2_min1(PIX);
  localparam int RW   = clog2_min1(ROWS);
  localparam int GMAX = (ROW_GAP > FRAME_GAP) ? ROW_GAP : FRAME_GAP;
  localparam int GW   = clog2_min1(GMAX);
  localparam int IW   = clog2_min1(display_pkg::DIS_WORDS);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [GW-1:0] RGAP_LAST  = GW'(ROW_GAP - 1);
  localparam logic [GW-1:0] FGAP_LAST  = GW'(FRAME_GAP - 1);

  if (ROWS * WORDS_PER_ROW > display_pkg::DIS_WORDS) begin : g_bad_size
    $error("display_scanout: ROWS*WORDS_PER_ROW exceeds the display window");
  end

  scan_state_t    state;
  logic [RW-1:0]  row_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [IW-1:0]  base;
  logic [PIX-1:0] row_bits;
  logic [BW-1:0]  bit_cnt;
  logic           load, xfer, eol;

  always_comb begin
    row_bits = '0;
    base     = IW'(row_cnt) * IW'(WORDS_PER_ROW);
    for (int k = 0; k < WORDS_PER_ROW; k++)
      row_bits[PIX-1-32*k -: 32] = dis[base + IW'(k)];
  end

  // A pixel moves when pix_valid & pix_ready at a rising edge; once raised,
  // pix_valid and the pixel/markers hold until that transfer (or reset).
  assign load = (state == display_pkg::LOAD);
  assign xfer = pix_valid & pix_ready;

  scan_row_shifter #(.PIX(PIX), .BW(BW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (xfer),
    .row_bits (row_bits),
    .data     (pix_data),
    .eol      (eol),
    .bit_cnt  (bit_cnt)
  );

  assign pix_sof   = pix_valid && (row_cnt == '0) && (bit_cnt == '0);
  assign pix_eol   = pix_valid & eol;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= display_pkg::IDLE;
      row_cnt    <= '0;
      gap_cnt    <= '0;
      pix_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        display_pkg::IDLE: begin
          if (en) begin
            state   <= display_pkg::LOAD;
            row_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        display_pkg::LOAD: begin
          state     <= display_pkg::SEND;
          pix_valid <= 1'b1;
        end
        display_pkg::SEND: begin
          if (xfer && eol) begin
            pix_valid <= 1'b0;
            gap_cnt   <= '0;
            if (row_cnt != LAST_ROW) begin
              row_cnt <= row_cnt + 1'b1;
              state   <= (ROW_GAP == 0) ? display_pkg::LOAD : display_pkg::ROW_GAP;
            end else begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
              if (FRAME_GAP != 0) begin
                state <= display_pkg::FRAME_GAP;
              end else if (en) begin
                state   <= display_pkg::LOAD;
                row_cnt <= '0;
              end else begin
                state <= display_pkg::IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        display_pkg::ROW_GAP: begin
          if (gap_cnt == RGAP_LAST) state <= display_pkg::LOAD;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        display_pkg::FRAME_GAP: begin
          if (gap_cnt == FGAP_LAST) begin
            if (en) begin
              state   <= display_pkg::LOAD;
              row_cnt <= '0;
            end else begin
              state <= display_pkg::IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state     <= display_pkg::IDLE;
          busy      <= 1'b0;
          pix_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout with the default 48x64 geometry and gaps.
module tb_display_scanout;
  import display_pkg::*;

  localparam int NPIX = 3072;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        pix_ready = 1'b1;
  logic [31:0] mem [0:95];
  logic        pix_valid, pix_data, pix_sof, pix_eol, frame_done, busy;
  logic [15:0] frame_cnt;
  scan_state_t dbg_state;

  display_scanout dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dis        (mem),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
  end

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  int          pos = 0;
  logic [31:0] cur_word = '0;
  logic        got_bits [0:NPIX-1];
  int          sof_err = 0, eol_err = 0, stall_err = 0, stall_cycles = 0, fd_seen = 0;
  logic        stalled = 1'b0;
  logic [2:0]  held = '0;

  always @(negedge clk) begin
    if (!rst) begin
      pos = 0;
      stalled = 1'b0;
      cur_word = '0;
    end else begin
      if (frame_done) fd_seen++;
      if (stalled && (!pix_valid || {pix_data, pix_sof, pix_eol} != held)) stall_err++;
      if (pix_valid && !pix_ready) begin
        stalled = 1'b1;
        held = {pix_data, pix_sof, pix_eol};
        stall_cycles++;
      end else begin
        stalled = 1'b0;
      end
      if (pix_valid && pix_ready) begin
        if (pix_sof != (pos == 0)) sof_err++;
        if (pix_eol != (pos % 64 == 63)) eol_err++;
        got_bits[pos] = pix_data;
        cur_word = {cur_word[30:0], pix_data};
        if (pos % 32 == 31) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL pix_word: got %h with no expected word queued", cur_word);
          end else begin
            check("pix_word", cur_word, exp_q.pop_front());
          end
        end
        pos = (pos == NPIX - 1) ? 0 : pos + 1;
      end
    end
  end

  // driver tasks
  task automatic clear_mem();
    for (int i = 0; i < 96; i++) mem[i] = '0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 96; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wait_fd(input string name, input int budget, output int fcyc);
    int n;
    n = 0;
    fcyc = -1;
    while (n < budget) begin
      @(negedge clk);
      if (frame_done) begin
        fcyc = cyc;
        break;
      end
      n++;
    end
    if (fcyc < 0) begin
      total++;
      $display("FAIL %s: no frame_done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    int          widx;
    logic [31:0] val;
    int          one_a;
    int          one_b;
    int          n_ones;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int fcyc, lcyc, fd0, bad, ones, n;

    vecs[0] = '{0,  32'h8000_0001, 0,    31,   2};
    vecs[1] = '{1,  32'h0000_0001, 63,   63,   1};
    vecs[2] = '{2,  32'h8000_0000, 64,   64,   1};
    vecs[3] = '{95, 32'h0000_0001, 3071, 3071, 1};
    vecs[4] = '{10, 32'h0001_0000, 335,  335,  1};
    vecs[5] = '{47, 32'hC000_0000, 1504, 1505, 2};

    clear_mem();

    // reset and quiet idle
    repeat (3) @(negedge clk);
    check("rst_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_flags", {pix_sof, pix_eol, pix_data, frame_done}, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1 rst = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || pix_valid || pix_sof || pix_eol || frame_done || pix_data || frame_cnt != 0) bad++;
    end
    check("idle_quiet", bad, 0);

    // single-word pattern frames with en dropped after start
    for (int k = 0; k < 6; k++) begin
      clear_mem();
      mem[vecs[k].widx] = vecs[k].val;
      push_frame();
      fd0 = fd_seen;
      @(posedge clk); #1 en = 1'b1;
      @(negedge clk);
      check("lat_busy_n", busy, 0);
      @(negedge clk);
      check("lat_busy_n1", busy, 1);
      check("lat_load", dbg_state, LOAD);
      lcyc = cyc;
      @(negedge clk);
      check("lat_valid_n2", pix_valid, 1);
      check("lat_sof", pix_sof, 1);
      en = 1'b0;
      wait_fd("vec_fd", 4000, fcyc);
      if (fcyc >= 0) check("vec_fd_time", fcyc - lcyc, 3308);
      check("vec_fcnt", frame_cnt, k + 1);
      bad = 0;
      repeat (15) begin
        @(negedge clk);
        if (!busy) bad++;
      end
      check("vec_gap_busy", bad, 0);
      @(negedge clk);
      check("vec_idle_busy", busy, 0);
      check("vec_idle_state", dbg_state, IDLE);
      #2;
      ones = 0;
      for (int i = 0; i < NPIX; i++) if (got_bits[i]) ones++;
      check("vec_one_a", got_bits[vecs[k].one_a], 1);
      check("vec_one_b", got_bits[vecs[k].one_b], 1);
      check("vec_popcount", ones, vecs[k].n_ones);
      check("vec_fd_count", fd_seen - fd0, 1);
      check("vec_q_empty", exp_q.size(), 0);
    end

    // backpressure over two back-to-back frames
    for (int i = 0; i < 96; i++) mem[i] = (32'(i) * 32'h01F3_A5C7) ^ 32'h5A5A_A5A5;
    push_frame();
    push_frame();
    fd0 = fd_seen;
    rand_ready = 1'b1;
    @(posedge clk); #1 en = 1'b1;
    wait_fd("bp_fd1", 20000, fcyc);
    repeat (40) @(negedge clk);
    en = 1'b0;
    wait_fd("bp_fd2", 20000, fcyc);
    rand_ready = 1'b0;
    pix_ready = 1'b1;
    wait_idle("bp_idle");
    #2;
    check("bp_fd_count", fd_seen - fd0, 2);
    check("bp_fcnt", frame_cnt, 8);
    check("bp_stall_stable", stall_err, 0);
    check("bp_stalls_seen", stall_cycles > 0, 1);
    check("bp_q_empty", exp_q.size(), 0);

    // snapshot: row 0 torn write shows next frame, row 5 write shows now
    clear_mem();
    mem[10] = 32'h1234_5678;
    push_frame();
    mem[0] = 32'hFFFF_FFFF;
    push_frame();
    mem[0] = '0;
    mem[10] = '0;
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(pix_valid && pix_sof) && n < 10);
    check("snap_sof_seen", pix_valid && pix_sof, 1);
    @(posedge clk); #1;
    mem[0] = 32'hFFFF_FFFF;
    mem[10] = 32'h1234_5678;
    wait_fd("snap_fd_a", 4000, fcyc);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dbg_state != LOAD && n < 40);
    check("snap_gap_load", cyc - fcyc, 16);
    en = 1'b0;
    wait_fd("snap_fd_b", 4000, fcyc);
    wait_idle("snap_idle");
    #2;
    check("snap_fcnt", frame_cnt, 10);
    check("snap_q_empty", exp_q.size(), 0);

    // asynchronous reset in the middle of row 7
    for (int i = 0; i < 96; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    push_frame();
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    do begin
      @(negedge clk); #2;
      n++;
    end while (pos < 7 * 64 + 10 && n < 2000);
    check("rr_row7_reached", pos, 7 * 64 + 10);
    rst = 1'b0;
    #1;
    check("rr_valid_low", pix_valid, 0);
    check("rr_busy_low", busy, 0);
    check("rr_fcnt", frame_cnt, 0);
    check("rr_state", dbg_state, IDLE);
    exp_q.delete();
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    push_frame();
    @(posedge clk); #1 en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pix_valid && n < 5);
    check("rr_restart_sof", pix_sof, 1);
    en = 1'b0;
    wait_fd("rr_fd", 4000, fcyc);
    check("rr_fcnt_after", frame_cnt, 1);
    wait_idle("rr_idle");
    #2;
    check("rr_q_empty", exp_q.size(), 0);
    check("sof_markers", sof_err, 0);
    check("eol_markers", eol_err, 0);
    check("stall_stable", stall_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
